edge_capture_pio: RTL

Parametrised Avalon-MM input PIO: the multi-bit successor to the single-bit done/status input ports. It synchronises and optionally debounces WIDTH asynchronous inputs, and captures rising and/or falling edges per bit with runtime selection. Captures are sticky, write-1-to-clear and maskable, and drive a level interrupt. It sits on the HPS/Nios lightweight bus as a slave in the Qsys system.

---
 rtl/edge_pio_pkg.sv | 24 ++
 rtl/edge_pio_channel.sv | 63 ++++++
 rtl/edge_capture_pio.sv | 111 +++++++++++
 3 files changed

// File: rtl/edge_pio_pkg.sv
// edge_pio_pkg: shared register addresses and parameter legality checks for
// the edge-capturing Avalon-MM input PIO.
package edge_pio_pkg;

   localparam logic [2:0] ADDR_DATA     = 3'd0;
   localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
   localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
   localparam logic [2:0] ADDR_RISE_EN  = 3'd4;
   localparam logic [2:0] ADDR_FALL_EN  = 3'd5;

   // True when the parameter set is buildable: 1..32 channels, at least two
   // synchroniser flops, and a debounce counter wide enough to reach its limit.
   function automatic bit paramsLegal(input int width, input int syncStages,
                                      input int debounceCycles, input int cntW);
      bit ok;
      ok = (width >= 1) && (width <= 32) && (syncStages >= 2) &&
           (debounceCycles >= 1) && (cntW >= 1);
      if (ok && cntW < 31) begin
         ok = (longint'(1) << cntW) > longint'(debounceCycles);
      end
      return ok;
   endfunction

endpackage

// File: rtl/edge_pio_channel.sv
// edge_pio_channel: one input bit -- synchroniser, debounce filter and
// enable-qualified rise/fall detection on the filtered value.
module edge_pio_channel
   import edge_pio_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1,
   parameter int CNT_W           = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic in_i,
   input  logic riseEn_i,
   input  logic fallEn_i,
   output logic filt_o,
   output logic rise_o,
   output logic fall_o
);

   localparam logic [CNT_W-1:0] LastCnt = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   filt_q, filt_d;
   logic                   filtPrev_q;
   logic                   syncOut;

   assign syncOut = sync_q[SYNC_STAGES-1];

   // Filtered value only follows the synchronised input after it has
   // differed for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts.
   always_comb begin
      cnt_d  = '0;
      filt_d = filt_q;
      if (syncOut != filt_q) begin
         if (cnt_q == LastCnt) begin
            filt_d = syncOut;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // Synchroniser chain, debounce state and the one-cycle-old filtered value.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q     <= '0;
         cnt_q      <= '0;
         filt_q     <= 1'b0;
         filtPrev_q <= 1'b0;
      end else begin
         sync_q     <= {sync_q[SYNC_STAGES-2:0], in_i};
         cnt_q      <= cnt_d;
         filt_q     <= filt_d;
         filtPrev_q <= filt_q;
      end
   end

   assign filt_o = filt_q;
   assign rise_o = filt_q & ~filtPrev_q & riseEn_i;
   assign fall_o = ~filt_q & filtPrev_q & fallEn_i;

endmodule

// File: rtl/edge_capture_pio.sv
// edge_capture_pio: Avalon-MM slave with WIDTH debounced inputs, sticky
// write-1-to-clear edge captures, runtime rise/fall enables and a masked irq.
module edge_capture_pio
   import edge_pio_pkg::*;
#(
   parameter int WIDTH           = 8,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1,
   parameter int CNT_W           = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   if (!paramsLegal(WIDTH, SYNC_STAGES, DEBOUNCE_CYCLES, CNT_W)) begin : gBadParams
      $error("edge_capture_pio: illegal parameter combination");
   end

   logic [WIDTH-1:0] filt, rise, fall;
   logic [WIDTH-1:0] irqMask_q, irqMask_d;
   logic [WIDTH-1:0] edgeCap_q, edgeCap_d;
   logic [WIDTH-1:0] riseEn_q, riseEn_d;
   logic [WIDTH-1:0] fallEn_q, fallEn_d;
   logic [31:0]      readdata_q, readdata_d;
   logic             irq_q, irq_d;
   logic             strobe;
   logic [WIDTH-1:0] wrData;
   logic [WIDTH-1:0] clr;
   logic             unusedWriteBits;

   // Upper write-data bits beyond WIDTH are intentionally ignored.
   assign unusedWriteBits = ^writedata;

   for (genvar i = 0; i < WIDTH; i++) begin : gChan
      edge_pio_channel #(
         .SYNC_STAGES    (SYNC_STAGES),
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .CNT_W          (CNT_W)
      ) uChan (
         .clk     (clk),
         .reset_n (reset_n),
         .in_i    (in_port[i]),
         .riseEn_i(riseEn_q[i]),
         .fallEn_i(fallEn_q[i]),
         .filt_o  (filt[i]),
         .rise_o  (rise[i]),
         .fall_o  (fall[i])
      );
   end

   // Register writes, W1C capture update (new edge beats a clear), irq and
   // the read mux, which samples every cycle regardless of chipselect.
   always_comb begin
      strobe     = chipselect && !write_n;
      wrData     = writedata[WIDTH-1:0];
      irqMask_d  = irqMask_q;
      riseEn_d   = riseEn_q;
      fallEn_d   = fallEn_q;
      clr        = '0;
      readdata_d = '0;
      if (strobe) begin
         case (address)
            ADDR_IRQ_MASK: irqMask_d = wrData;
            ADDR_EDGE_CAP: clr       = wrData;
            ADDR_RISE_EN:  riseEn_d  = wrData;
            ADDR_FALL_EN:  fallEn_d  = wrData;
            default:       ;
         endcase
      end
      edgeCap_d = (edgeCap_q & ~clr) | rise | fall;
      irq_d     = |(edgeCap_q & irqMask_q);
      case (address)
         ADDR_DATA:     readdata_d[WIDTH-1:0] = filt;
         ADDR_IRQ_MASK: readdata_d[WIDTH-1:0] = irqMask_q;
         ADDR_EDGE_CAP: readdata_d[WIDTH-1:0] = edgeCap_q;
         ADDR_RISE_EN:  readdata_d[WIDTH-1:0] = riseEn_q;
         ADDR_FALL_EN:  readdata_d[WIDTH-1:0] = fallEn_q;
         default:       ;
      endcase
   end

   // Control/status registers; FALL_EN resets to all-ones for legacy behaviour.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irqMask_q  <= '0;
         edgeCap_q  <= '0;
         riseEn_q   <= '0;
         fallEn_q   <= '1;
         readdata_q <= '0;
         irq_q      <= 1'b0;
      end else begin
         irqMask_q  <= irqMask_d;
         edgeCap_q  <= edgeCap_d;
         riseEn_q   <= riseEn_d;
         fallEn_q   <= fallEn_d;
         readdata_q <= readdata_d;
         irq_q      <= irq_d;
      end
   end

   assign readdata = readdata_q;
   assign irq      = irq_q;

endmodule
